// File: rtl/issue_queue_pkg.sv
// Shared constants for the issue queue slice.
// Holds the micro-op field widths, the default parameter values and the
// packed micro-op descriptor that travels with every queue entry.
package issue_queue_pkg;

  localparam int OPCODE_W     = 7;
  localparam int FUNC3_W      = 3;
  localparam int FUNC1_W      = 1;

  localparam int IQ_DEPTH_DEF = 16;
  localparam int ROB_W_DEF    = 4;
  localparam int DATA_W_DEF   = 32;
  localparam int NCDB_DEF     = 2;

  // Decoded operation fields carried unchanged from dispatch to issue.
  typedef struct packed {
    logic [OPCODE_W-1:0] opcode;
    logic [FUNC3_W-1:0]  func3;
    logic [FUNC1_W-1:0]  func1;
  } uop_t;

endpackage

// File: rtl/age_select.sv
// Oldest-ready picker for the issue queue.
// Ports:
//   ready       - per-entry "may issue" vector
//   age         - age[i][j] = 1 when entry i is older than entry j
//   grant_idx   - index of the oldest ready entry
//   grant_valid - at least one entry is ready
// An entry wins when it is older than every other ready entry. A consistent
// age matrix yields at most one winner, so the index can be OR-reduced.
module age_select #(
  parameter int DEPTH = 16
) (
  input  logic [DEPTH-1:0]             ready,
  input  logic [DEPTH-1:0][DEPTH-1:0]  age,
  output logic [$clog2(DEPTH)-1:0]     grant_idx,
  output logic                         grant_valid
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [DEPTH-1:0] ONE_HOT0 = {{(DEPTH-1){1'b0}}, 1'b1};

  logic [DEPTH-1:0] cand_s;

  // Find the ready entry older than all other ready entries and encode it.
  always_comb begin
    cand_s      = '0;
    grant_idx   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      cand_s[i] = ready[i] & ~(|(ready & ~age[i] & ~(ONE_HOT0 << i)));
    end
    for (int i = 0; i < DEPTH; i++) begin
      grant_idx = grant_idx | (cand_s[i] ? IDX_W'(i) : IDX_W'(0));
    end
    grant_valid = |cand_s;
  end

endmodule

// File: rtl/issue_queue.sv
// Out-of-order issue queue with tag wakeup and oldest-first selection.
// Ports:
//   clk, rst (async, active low), rdy (global enable), rollback (sync flush)
//   in_*     - dispatch side; in_ready when an entry is free
//   out_*    - registered issue slot towards the ALU, out_valid/out_ready
//   cdb_*    - NCDB result broadcast ports, port k in slice k
//   count    - number of busy entries
// Entries wait until both operands are present, then the oldest ready one is
// loaded into the output register and its slot is freed on the same edge.
module issue_queue
  import issue_queue_pkg::*;
#(
  parameter int DEPTH  = IQ_DEPTH_DEF,
  parameter int ROB_W  = ROB_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int NCDB   = NCDB_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       rdy,
  input  logic                       rollback,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [OPCODE_W-1:0]        in_opcode,
  input  logic [FUNC3_W-1:0]         in_func3,
  input  logic [FUNC1_W-1:0]         in_func1,
  input  logic [ROB_W-1:0]           in_rob_pos,
  input  logic [DATA_W-1:0]          in_rs1_val,
  input  logic [DATA_W-1:0]          in_rs2_val,
  input  logic                       in_rs1_pend,
  input  logic                       in_rs2_pend,
  input  logic [ROB_W-1:0]           in_rs1_tag,
  input  logic [ROB_W-1:0]           in_rs2_tag,
  input  logic [DATA_W-1:0]          in_imm,
  input  logic [DATA_W-1:0]          in_pc,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [OPCODE_W-1:0]        out_opcode,
  output logic [FUNC3_W-1:0]         out_func3,
  output logic [FUNC1_W-1:0]         out_func1,
  output logic [DATA_W-1:0]          out_val1,
  output logic [DATA_W-1:0]          out_val2,
  output logic [DATA_W-1:0]          out_imm,
  output logic [DATA_W-1:0]          out_pc,
  output logic [ROB_W-1:0]           out_rob_pos,
  input  logic [NCDB-1:0]            cdb_valid,
  input  logic [NCDB*ROB_W-1:0]      cdb_tag,
  input  logic [NCDB*DATA_W-1:0]     cdb_val,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = IDX_W + 1;

  // Control state (reset)
  logic [DEPTH-1:0]            busy_r;
  logic [DEPTH-1:0]            pend1_r;
  logic [DEPTH-1:0]            pend2_r;
  logic [DEPTH-1:0][DEPTH-1:0] age_r;
  logic [CNT_W-1:0]            count_r;
  logic                        in_ready_r;
  logic                        out_valid_r;
  uop_t                        out_uop_r;
  logic [ROB_W-1:0]            out_rob_r;
  logic [DATA_W-1:0]           out_val1_r;
  logic [DATA_W-1:0]           out_val2_r;
  logic [DATA_W-1:0]           out_imm_r;
  logic [DATA_W-1:0]           out_pc_r;

  // Payload storage (not reset, only meaningful while busy)
  uop_t                        uop_r  [DEPTH];
  logic [ROB_W-1:0]            rob_r  [DEPTH];
  logic [ROB_W-1:0]            tag1_r [DEPTH];
  logic [ROB_W-1:0]            tag2_r [DEPTH];
  logic [DATA_W-1:0]           val1_r [DEPTH];
  logic [DATA_W-1:0]           val2_r [DEPTH];
  logic [DATA_W-1:0]           imm_r  [DEPTH];
  logic [DATA_W-1:0]           pc_r   [DEPTH];

  logic [DEPTH-1:0]            ready_s;
  logic [IDX_W-1:0]            grant_idx_s;
  logic                        grant_valid_s;
  logic [IDX_W-1:0]            free_idx_s;
  logic                        load_s;
  logic                        issue_s;
  logic                        disp_s;
  logic [CNT_W-1:0]            count_next_s;
  logic [DATA_W:0]             wake1_s [DEPTH];
  logic [DATA_W:0]             wake2_s [DEPTH];
  logic [DATA_W:0]             byp1_s;
  logic [DATA_W:0]             byp2_s;

  // Returns {hit, value} for a tag against all broadcast ports. Ports are
  // walked from the highest down so the lowest matching port has the last say.
  function automatic logic [DATA_W:0] cdb_match(
    input logic [ROB_W-1:0]       tag,
    input logic [NCDB-1:0]        vld,
    input logic [NCDB*ROB_W-1:0]  tags,
    input logic [NCDB*DATA_W-1:0] vals
  );
    logic [DATA_W:0] res;
    res = '0;
    for (int k = NCDB - 1; k >= 0; k--) begin
      res = (vld[k] && (tags[k*ROB_W +: ROB_W] == tag)) ?
            {1'b1, vals[k*DATA_W +: DATA_W]} : res;
    end
    return res;
  endfunction

  assign ready_s      = busy_r & ~pend1_r & ~pend2_r;
  assign load_s       = ~out_valid_r | out_ready;
  assign issue_s      = rdy & ~rollback & load_s & grant_valid_s;
  assign disp_s       = rdy & ~rollback & in_valid & in_ready_r;
  assign count_next_s = count_r + CNT_W'(disp_s) - CNT_W'(issue_s);

  // Lowest-index free slot; scanning downward lets the lowest index win.
  always_comb begin
    free_idx_s = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      free_idx_s = busy_r[i] ? free_idx_s : IDX_W'(i);
    end
  end

  // Tag matches for stored operands and for the operands being dispatched.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      wake1_s[i] = cdb_match(tag1_r[i], cdb_valid, cdb_tag, cdb_val);
      wake2_s[i] = cdb_match(tag2_r[i], cdb_valid, cdb_tag, cdb_val);
    end
    byp1_s = cdb_match(in_rs1_tag, cdb_valid, cdb_tag, cdb_val);
    byp2_s = cdb_match(in_rs2_tag, cdb_valid, cdb_tag, cdb_val);
  end

  age_select #(
    .DEPTH(DEPTH)
  ) u_age_select (
    .ready       (ready_s),
    .age         (age_r),
    .grant_idx   (grant_idx_s),
    .grant_valid (grant_valid_s)
  );

  // Busy/pending bookkeeping, age matrix, occupancy and the issue register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_r      <= '0;
      pend1_r     <= '0;
      pend2_r     <= '0;
      age_r       <= '0;
      count_r     <= '0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      out_uop_r   <= '0;
      out_rob_r   <= '0;
      out_val1_r  <= '0;
      out_val2_r  <= '0;
      out_imm_r   <= '0;
      out_pc_r    <= '0;
    end else if (rdy && rollback) begin
      busy_r      <= '0;
      pend1_r     <= '0;
      pend2_r     <= '0;
      age_r       <= '0;
      count_r     <= '0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else if (rdy) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (busy_r[i] && pend1_r[i] && wake1_s[i][DATA_W]) begin
          pend1_r[i] <= 1'b0;
        end
        if (busy_r[i] && pend2_r[i] && wake2_s[i][DATA_W]) begin
          pend2_r[i] <= 1'b0;
        end
      end
      if (load_s) begin
        out_valid_r <= grant_valid_s;
      end
      if (issue_s) begin
        busy_r[grant_idx_s] <= 1'b0;
        out_uop_r           <= uop_r[grant_idx_s];
        out_rob_r           <= rob_r[grant_idx_s];
        out_val1_r          <= val1_r[grant_idx_s];
        out_val2_r          <= val2_r[grant_idx_s];
        out_imm_r           <= imm_r[grant_idx_s];
        out_pc_r            <= pc_r[grant_idx_s];
      end
      if (disp_s) begin
        busy_r[free_idx_s]  <= 1'b1;
        pend1_r[free_idx_s] <= in_rs1_pend & ~byp1_s[DATA_W];
        pend2_r[free_idx_s] <= in_rs2_pend & ~byp2_s[DATA_W];
        // The newcomer is younger than every entry busy before this edge.
        for (int k = 0; k < DEPTH; k++) begin
          age_r[k][free_idx_s] <= busy_r[k];
          age_r[free_idx_s][k] <= 1'b0;
        end
      end
      count_r    <= count_next_s;
      in_ready_r <= (count_next_s < CNT_W'(DEPTH));
    end
  end

  // Entry payload: written at dispatch (with CDB bypass) and on wakeup.
  always_ff @(posedge clk) begin
    if (rdy && !rollback) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (busy_r[i] && pend1_r[i] && wake1_s[i][DATA_W]) begin
          val1_r[i] <= wake1_s[i][DATA_W-1:0];
        end
        if (busy_r[i] && pend2_r[i] && wake2_s[i][DATA_W]) begin
          val2_r[i] <= wake2_s[i][DATA_W-1:0];
        end
      end
      if (disp_s) begin
        uop_r[free_idx_s]  <= '{opcode: in_opcode, func3: in_func3, func1: in_func1};
        rob_r[free_idx_s]  <= in_rob_pos;
        tag1_r[free_idx_s] <= in_rs1_tag;
        tag2_r[free_idx_s] <= in_rs2_tag;
        imm_r[free_idx_s]  <= in_imm;
        pc_r[free_idx_s]   <= in_pc;
        val1_r[free_idx_s] <= (in_rs1_pend && byp1_s[DATA_W]) ? byp1_s[DATA_W-1:0] : in_rs1_val;
        val2_r[free_idx_s] <= (in_rs2_pend && byp2_s[DATA_W]) ? byp2_s[DATA_W-1:0] : in_rs2_val;
      end
    end
  end

  assign in_ready    = in_ready_r;
  assign count       = count_r;
  assign out_valid   = out_valid_r;
  assign out_opcode  = out_uop_r.opcode;
  assign out_func3   = out_uop_r.func3;
  assign out_func1   = out_uop_r.func1;
  assign out_rob_pos = out_rob_r;
  assign out_val1    = out_val1_r;
  assign out_val2    = out_val2_r;
  assign out_imm     = out_imm_r;
  assign out_pc      = out_pc_r;

endmodule

// File: tb/tb_issue_queue.sv
// Self-checking bench for issue_queue. A behavioural model keeps the waiting
// instructions as a list in arrival order; each clock it picks the first one
// whose operands are both present. Issued instructions and per-cycle status
// go into scoreboard queues that an independent monitor checks against the DUT.
module tb_issue_queue;

  localparam int DEPTH  = 16;
  localparam int ROB_W  = 4;
  localparam int DATA_W = 32;
  localparam int NCDB   = 2;

  logic        clk, rst, rdy, rollback;
  logic        in_valid, in_ready;
  logic [6:0]  in_opcode;
  logic [2:0]  in_func3;
  logic [0:0]  in_func1;
  logic [3:0]  in_rob_pos, in_rs1_tag, in_rs2_tag;
  logic [31:0] in_rs1_val, in_rs2_val, in_imm, in_pc;
  logic        in_rs1_pend, in_rs2_pend;
  logic        out_valid, out_ready;
  logic [6:0]  out_opcode;
  logic [2:0]  out_func3;
  logic [0:0]  out_func1;
  logic [31:0] out_val1, out_val2, out_imm, out_pc;
  logic [3:0]  out_rob_pos;
  logic [1:0]  cdb_valid;
  logic [7:0]  cdb_tag;
  logic [63:0] cdb_val;
  logic [4:0]  count;

  issue_queue #(.DEPTH(DEPTH), .ROB_W(ROB_W), .DATA_W(DATA_W), .NCDB(NCDB)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .rollback(rollback),
    .in_valid(in_valid), .in_ready(in_ready), .in_opcode(in_opcode),
    .in_func3(in_func3), .in_func1(in_func1), .in_rob_pos(in_rob_pos),
    .in_rs1_val(in_rs1_val), .in_rs2_val(in_rs2_val),
    .in_rs1_pend(in_rs1_pend), .in_rs2_pend(in_rs2_pend),
    .in_rs1_tag(in_rs1_tag), .in_rs2_tag(in_rs2_tag),
    .in_imm(in_imm), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_opcode(out_opcode),
    .out_func3(out_func3), .out_func1(out_func1), .out_val1(out_val1),
    .out_val2(out_val2), .out_imm(out_imm), .out_pc(out_pc),
    .out_rob_pos(out_rob_pos), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag),
    .cdb_val(cdb_val), .count(count)
  );

  typedef struct packed {
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic [0:0]  f1;
    logic [3:0]  rob;
    logic [31:0] v1, v2;
    logic        p1, p2;
    logic [3:0]  t1, t2;
    logic [31:0] imm, pc;
  } ent_t;

  typedef struct packed {
    logic [4:0] cnt;
    logic       irdy;
    logic       ov;
    logic [3:0] rob;
    logic       is_rst;
  } stat_t;

  ent_t  ents[$];    // waiting instructions, oldest first
  ent_t  exp_q[$];   // instructions expected at the ALU port, in order
  stat_t stat_q[$];  // expected status after each clock
  ent_t  m_out;
  logic  m_ov;
  int    checks, failures;
  ent_t  mon_e;
  stat_t mon_s;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // First broadcast port (lowest index) carrying this tag, if any.
  function automatic logic lookup(input logic [3:0] tag, output logic [31:0] v);
    v = 32'd0;
    for (int k = 0; k < NCDB; k++) begin
      if (cdb_valid[k] && cdb_tag[k*4 +: 4] == tag) begin
        v = cdb_val[k*32 +: 32];
        return 1'b1;
      end
    end
    return 1'b0;
  endfunction

  function automatic void model_reset();
    ents.delete();
    exp_q.delete();
    m_ov  = 1'b0;
    m_out = '0;
  endfunction

  function automatic void push_status();
    stat_t s;
    s.cnt    = 5'(ents.size());
    s.irdy   = (ents.size() < DEPTH);
    s.ov     = m_ov;
    s.rob    = m_out.rob;
    s.is_rst = !rst;
    stat_q.push_back(s);
  endfunction

  // Advance the model by one clock using the inputs the DUT just sampled.
  function automatic void model_step();
    int          idx, n0;
    logic [31:0] v;
    ent_t        e;
    if (!rst) begin
      model_reset();
    end else if (rdy && rollback) begin
      ents.delete();
      exp_q.delete();
      m_ov = 1'b0;
    end else if (rdy) begin
      n0 = ents.size();
      if (!m_ov || out_ready) begin
        idx = -1;
        foreach (ents[i]) if (idx < 0 && !ents[i].p1 && !ents[i].p2) idx = i;
        if (idx >= 0) begin
          m_out = ents[idx];
          ents.delete(idx);
          m_ov = 1'b1;
          exp_q.push_back(m_out);
        end else begin
          m_ov = 1'b0;
        end
      end
      foreach (ents[i]) begin
        e = ents[i];
        if (e.p1 && lookup(e.t1, v)) begin e.v1 = v; e.p1 = 1'b0; end
        if (e.p2 && lookup(e.t2, v)) begin e.v2 = v; e.p2 = 1'b0; end
        ents[i] = e;
      end
      if (in_valid && n0 < DEPTH) begin
        e = '{opc: in_opcode, f3: in_func3, f1: in_func1, rob: in_rob_pos,
              v1: in_rs1_val, v2: in_rs2_val, p1: in_rs1_pend, p2: in_rs2_pend,
              t1: in_rs1_tag, t2: in_rs2_tag, imm: in_imm, pc: in_pc};
        if (e.p1 && lookup(e.t1, v)) begin e.v1 = v; e.p1 = 1'b0; end
        if (e.p2 && lookup(e.t2, v)) begin e.v2 = v; e.p2 = 1'b0; end
        ents.push_back(e);
      end
    end
    push_status();
  endfunction

  task automatic cycle();
    @(posedge clk);
    #2;
    model_step();
  endtask

  task automatic idle();
    rdy = 1'b1; rollback = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_rs1_pend = 1'b0; in_rs2_pend = 1'b0; in_rs1_tag = 4'd0; in_rs2_tag = 4'd0;
    cdb_valid = 2'b00; cdb_tag = 8'd0; cdb_val = 64'd0;
  endtask

  task automatic disp(input logic [3:0] rob, input logic p1, input logic [3:0] t1,
                      input logic p2, input logic [3:0] t2);
    in_valid = 1'b1; in_rob_pos = rob;
    in_opcode = 7'($urandom); in_func3 = 3'($urandom); in_func1 = 1'($urandom);
    in_rs1_val = $urandom; in_rs2_val = $urandom; in_imm = $urandom; in_pc = $urandom;
    in_rs1_pend = p1; in_rs1_tag = t1; in_rs2_pend = p2; in_rs2_tag = t2;
    cdb_valid = 2'b00;
  endtask

  task automatic rand_inputs();
    disp(4'($urandom), 1'($urandom), 4'($urandom), 1'($urandom), 4'($urandom));
    in_valid  = ($urandom_range(0, 3) != 0);
    cdb_valid = 2'($urandom);
    cdb_tag   = {4'($urandom), 4'($urandom)};
    if ($urandom_range(0, 3) == 0) cdb_tag[7:4] = cdb_tag[3:0];
    cdb_val   = {$urandom, $urandom};
    out_ready = ($urandom_range(0, 3) != 0);
    rdy       = ($urandom_range(0, 15) != 0);
    rollback  = ($urandom_range(0, 59) == 0);
  endtask

  task automatic async_reset();
    rst = 1'b0;
    model_reset();
    stat_q.delete();
    push_status();
    cycle();
    cycle();
    rst = 1'b1;
  endtask

  // Monitor: checks status every cycle and the issued payload on each transfer.
  initial begin
    checks = 0;
    failures = 0;
    forever begin
      @(negedge clk);
      if (stat_q.size() > 0) begin
        mon_s = stat_q.pop_front();
        checks++;
        if ({count, in_ready, out_valid} !== {mon_s.cnt, mon_s.irdy, mon_s.ov}) begin
          failures++;
          $display("FAIL status: count=%0d in_ready=%0d out_valid=%0d, expected count=%0d in_ready=%0d out_valid=%0d",
                   count, in_ready, out_valid, mon_s.cnt, mon_s.irdy, mon_s.ov);
        end
        if (mon_s.ov) begin
          checks++;
          if (out_rob_pos !== mon_s.rob) begin
            failures++;
            $display("FAIL out_rob_hold: out_rob_pos=%0d expected %0d", out_rob_pos, mon_s.rob);
          end
        end
        if (mon_s.is_rst) begin
          checks++;
          if ({out_opcode, out_func3, out_func1, out_rob_pos, out_val1, out_val2, out_imm, out_pc} !== '0) begin
            failures++;
            $display("FAIL reset_data: out_val1=%h out_pc=%h expected all zero", out_val1, out_pc);
          end
        end
      end
      if (rst && rdy && !rollback && out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL issue: rob=%0d presented but no instruction expected", out_rob_pos);
        end else begin
          mon_e = exp_q.pop_front();
          if ({out_opcode, out_func3, out_func1, out_rob_pos, out_val1, out_val2, out_imm, out_pc} !==
              {mon_e.opc, mon_e.f3, mon_e.f1, mon_e.rob, mon_e.v1, mon_e.v2, mon_e.imm, mon_e.pc}) begin
            failures++;
            $display("FAIL issue: got rob=%0d v1=%h v2=%h pc=%h op=%h, expected rob=%0d v1=%h v2=%h pc=%h op=%h",
                     out_rob_pos, out_val1, out_val2, out_pc, out_opcode,
                     mon_e.rob, mon_e.v1, mon_e.v2, mon_e.pc, mon_e.opc);
          end
        end
      end
    end
  end

  // Stimulus: directed scenarios followed by a randomized run.
  initial begin
    rst = 1'b0;
    in_opcode = 7'd0; in_func3 = 3'd0; in_func1 = 1'b0; in_rob_pos = 4'd0;
    in_rs1_val = 32'd0; in_rs2_val = 32'd0; in_imm = 32'd0; in_pc = 32'd0;
    idle();
    model_reset();
    cycle();
    cycle();
    rst = 1'b1;
    cycle();

    // Fill with ready instructions while the ALU is stalled.
    for (int n = 0; n < 18; n++) begin
      disp(4'(n), 1'b0, 4'd0, 1'b0, 4'd0);
      out_ready = 1'b0;
      cycle();
    end
    idle(); out_ready = 1'b0;
    repeat (2) cycle();
    out_ready = 1'b1;
    repeat (20) cycle();

    // Younger ready instruction overtakes an older waiting one.
    disp(4'd3, 1'b1, 4'd5, 1'b0, 4'd0); cycle();
    disp(4'd4, 1'b0, 4'd0, 1'b0, 4'd0); cycle();
    idle(); cdb_valid = 2'b01; cdb_tag = 8'h05; cdb_val = 64'h0000_0000_0000_00AA; cycle();
    idle(); repeat (4) cycle();

    // Same-cycle broadcast bypass on port 1.
    disp(4'd7, 1'b1, 4'd7, 1'b0, 4'd0);
    cdb_valid = 2'b10; cdb_tag = 8'h72; cdb_val = 64'h0000_1234_0000_5555;
    cycle();
    idle(); repeat (3) cycle();

    // Output stall holds the issued instruction.
    for (int n = 0; n < 3; n++) begin
      disp(4'(8 + n), 1'b0, 4'd0, 1'b0, 4'd0); out_ready = 1'b0; cycle();
    end
    idle(); out_ready = 1'b0;
    repeat (5) cycle();
    out_ready = 1'b1;
    repeat (6) cycle();

    // Rollback with six waiting entries and a same-cycle dispatch.
    for (int n = 0; n < 6; n++) begin
      disp(4'(n), 1'b1, 4'd9, 1'b0, 4'd0); cycle();
    end
    disp(4'd12, 1'b0, 4'd0, 1'b0, 4'd0); rollback = 1'b1; cycle();
    idle(); repeat (2) cycle();

    // Global enable low while dispatch and broadcast are active.
    for (int n = 0; n < 2; n++) begin
      disp(4'(n), 1'b1, 4'd10, 1'b0, 4'd0); cycle();
    end
    disp(4'd2, 1'b0, 4'd0, 1'b0, 4'd0);
    cdb_valid = 2'b01; cdb_tag = 8'h0A; cdb_val = 64'h0000_0000_0BAD_F00D; rdy = 1'b0;
    repeat (3) cycle();
    idle(); cdb_valid = 2'b01; cdb_tag = 8'h0A; cdb_val = 64'h0000_0000_1357_9BDF; cycle();
    idle(); repeat (4) cycle();

    // Randomized traffic with a reset in the middle.
    for (int n = 0; n < 2000; n++) begin
      rand_inputs();
      cycle();
      if (n == 1000) begin
        idle();
        async_reset();
      end
    end

    // Drain: wake every tag and let the queue empty.
    for (int n = 0; n < 40; n++) begin
      idle();
      cdb_valid = 2'b11;
      cdb_tag   = {4'(2 * n + 1), 4'(2 * n)};
      cdb_val   = {$urandom, $urandom};
      cycle();
    end
    idle();
    cycle();
    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
